// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, FSM states,
// instruction classes and the strobe bundle handed from decode to the top.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11011;
    localparam logic [4:0] OP_HALT = 5'b11100;

    // Low three bits step through T0..T6; bit 3 marks HALT.
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } instr_class_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic ry_in;
        logic rz_in_lo;
        logic rz_in_hi;
        logic rz_out_lo;
        logic rz_out_hi;
        logic lo_in;
        logic hi_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
    } strobes_t;

    function automatic instr_class_t op_class(input logic [4:0] op);
        instr_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:     cls = CLS_ALU3;
            OP_MUL, OP_DIV:                      cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                      cls = CLS_UNARY;
            OP_NOP:                              cls = CLS_NOP;
            OP_HALT:                             cls = CLS_HALT;
            default:                             cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode from the registered state and instruction class;
// clear or stop silence every strobe.
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t       state,
    input  instr_class_t cls,
    input  logic         stop,
    input  logic         clear,
    output strobes_t     strobes
);

    always_comb begin
        strobes = '0;
        if (!clear && !stop) begin
            case (state)
                S_T0: begin
                    strobes.pc_out   = 1'b1;
                    strobes.mar_in   = 1'b1;
                    strobes.inc_pc   = 1'b1;
                    strobes.rz_in_lo = 1'b1;
                end
                S_T1: begin
                    strobes.rz_out_lo = 1'b1;
                    strobes.pc_in     = 1'b1;
                    strobes.mdr_read  = 1'b1;
                    strobes.mdr_in    = 1'b1;
                end
                S_T2: begin
                    strobes.mdr_out = 1'b1;
                    strobes.ir_in   = 1'b1;
                end
                S_T3: begin
                    case (cls)
                        CLS_ALU3:   begin strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.ry_in = 1'b1; end
                        CLS_MULDIV: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.ry_in = 1'b1; end
                        CLS_UNARY:  begin strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.rz_in_lo = 1'b1; end
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (cls)
                        CLS_ALU3:   begin strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.rz_in_lo = 1'b1; end
                        CLS_MULDIV: begin
                            strobes.grb      = 1'b1;
                            strobes.r_out    = 1'b1;
                            strobes.rz_in_lo = 1'b1;
                            strobes.rz_in_hi = 1'b1;
                        end
                        CLS_UNARY:  begin strobes.rz_out_lo = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1; end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (cls)
                        CLS_ALU3:   begin strobes.rz_out_lo = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1; end
                        CLS_MULDIV: begin strobes.rz_out_lo = 1'b1; strobes.lo_in = 1'b1; end
                        default: ;
                    endcase
                end
                S_T6: begin
                    if (cls == CLS_MULDIV) begin
                        strobes.rz_out_hi = 1'b1;
                        strobes.hi_in     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: state register, next-state logic and the run/illegal
// flags; strobe generation lives in control_decode.
//   state  | meaning
//   S_T0   | fetch: PC to MAR, increment PC into Z
//   S_T1   | fetch: Z to PC, memory read into MDR
//   S_T2   | fetch: MDR to IR, opcode branch
//   S_T3-6 | execute steps, count depends on instruction class
//   S_HALT | stopped, no strobes, left only by clear
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int IR_W     = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [IR_W-1:0]     ir,
    input  logic                stop,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRread,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                RYin,
    output logic                RZinLo,
    output logic                RZinHi,
    output logic                RZoutLo,
    output logic                RZoutHi,
    output logic                LOin,
    output logic                HIin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                run,
    output logic                illegal
);

    state_t              state_q;
    state_t              state_d;
    logic                illegal_q;
    logic                run_q;
    logic [OPCODE_W-1:0] opcode;
    instr_class_t        cls;
    strobes_t            strobes;
    logic                in_exec;
    logic                unused_ir;

    assign opcode    = ir[IR_W-1 -: OPCODE_W];
    assign unused_ir = ^ir[IR_W-OPCODE_W-1:0];
    assign cls       = op_class(opcode);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: begin
                case (cls)
                    CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_d = S_T3;
                    CLS_HALT:                        state_d = S_HALT;
                    default:                         state_d = S_T0;
                endcase
            end
            S_T3: state_d = (cls == CLS_ALU3 || cls == CLS_MULDIV || cls == CLS_UNARY) ? S_T4 : S_T0;
            S_T4: state_d = (cls == CLS_ALU3 || cls == CLS_MULDIV) ? S_T5 : S_T0;
            S_T5: state_d = (cls == CLS_MULDIV) ? S_T6 : S_T0;
            S_T6: state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_T0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_T0;
            illegal_q <= 1'b0;
            run_q     <= 1'b1;
        end else if (!stop) begin
            state_q <= state_d;
            run_q   <= (state_d != S_HALT);
            if (state_q == S_T2 && cls == CLS_ILL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    control_decode u_decode (
        .state   (state_q),
        .cls     (cls),
        .stop    (stop),
        .clear   (clear),
        .strobes (strobes)
    );

    assign in_exec = (state_q == S_T3) || (state_q == S_T4) ||
                     (state_q == S_T5) || (state_q == S_T6);
    assign alu_op  = (in_exec && !stop && !clear) ? opcode : '0;

    assign PCout   = strobes.pc_out;
    assign PCin    = strobes.pc_in;
    assign IncPC   = strobes.inc_pc;
    assign MARin   = strobes.mar_in;
    assign MDRread = strobes.mdr_read;
    assign MDRin   = strobes.mdr_in;
    assign MDRout  = strobes.mdr_out;
    assign IRin    = strobes.ir_in;
    assign RYin    = strobes.ry_in;
    assign RZinLo  = strobes.rz_in_lo;
    assign RZinHi  = strobes.rz_in_hi;
    assign RZoutLo = strobes.rz_out_lo;
    assign RZoutHi = strobes.rz_out_hi;
    assign LOin    = strobes.lo_in;
    assign HIin    = strobes.hi_in;
    assign Gra     = strobes.gra;
    assign Grb     = strobes.grb;
    assign Grc     = strobes.grc;
    assign Rin     = strobes.r_in;
    assign Rout    = strobes.r_out;
    assign run     = run_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle pushes the expected
// strobe/alu_op/run/illegal word, which is popped and compared once outputs settle.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        stop  = 1'b0;
    logic [31:0] ir    = '0;
    logic PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout, IRin;
    logic RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [4:0] alu_op;
    logic run, illegal;

    control_sequencer #(.OPCODE_W(5), .IR_W(32)) dut (
        .clock(clock), .clear(clear), .ir(ir), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRread(MDRread), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .RYin(RYin), .RZinLo(RZinLo), .RZinHi(RZinHi), .RZoutLo(RZoutLo),
        .RZoutHi(RZoutHi), .LOin(LOin), .HIin(HIin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // Word layout: [26:7] strobes, [6:2] alu_op, [1] run, [0] illegal.
    localparam logic [26:0] PCOUT   = 27'd1 << 26;
    localparam logic [26:0] PCIN    = 27'd1 << 25;
    localparam logic [26:0] INCPC   = 27'd1 << 24;
    localparam logic [26:0] MARIN   = 27'd1 << 23;
    localparam logic [26:0] MDRREAD = 27'd1 << 22;
    localparam logic [26:0] MDRIN   = 27'd1 << 21;
    localparam logic [26:0] MDROUT  = 27'd1 << 20;
    localparam logic [26:0] IRIN    = 27'd1 << 19;
    localparam logic [26:0] RYIN    = 27'd1 << 18;
    localparam logic [26:0] RZINLO  = 27'd1 << 17;
    localparam logic [26:0] RZINHI  = 27'd1 << 16;
    localparam logic [26:0] RZOUTLO = 27'd1 << 15;
    localparam logic [26:0] RZOUTHI = 27'd1 << 14;
    localparam logic [26:0] LOIN    = 27'd1 << 13;
    localparam logic [26:0] HIIN    = 27'd1 << 12;
    localparam logic [26:0] GRA     = 27'd1 << 11;
    localparam logic [26:0] GRB     = 27'd1 << 10;
    localparam logic [26:0] GRC     = 27'd1 << 9;
    localparam logic [26:0] RIN     = 27'd1 << 8;
    localparam logic [26:0] ROUT    = 27'd1 << 7;
    localparam logic [26:0] ALL     = '1;
    localparam logic [26:0] NOALU   = ~(27'h1F << 2);
    localparam logic [26:0] NONE    = '0;

    localparam logic [31:0] IR_DIV  = 32'h79300000;
    localparam logic [31:0] IR_MUL  = 32'h70000000;
    localparam logic [31:0] IR_ADD  = 32'h02920000;
    localparam logic [31:0] IR_NEG  = 32'h80000000;
    localparam logic [31:0] IR_NOT  = 32'h88000000;
    localparam logic [31:0] IR_NOP  = 32'hD8000000;
    localparam logic [31:0] IR_HALT = 32'hE0000000;
    localparam logic [31:0] IR_ILL  = 32'hF8000000;

    typedef struct {
        logic [26:0] exp;
        logic [26:0] mask;
        string       tag;
    } sb_item_t;

    sb_item_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_run  = 1'b1;
    logic exp_ill  = 1'b0;

    task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %07h expected %07h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] word(input logic [26:0] s, input logic [4:0] a,
                                         input logic r, input logic il);
        return s | {20'b0, a, r, il};
    endfunction

    // Drive one cycle, push its expectation, then pop and compare once settled.
    task automatic cyc(input logic c, input logic s, input logic [31:0] irv,
                       input logic [26:0] strb, input logic [4:0] a,
                       input logic [26:0] mask, input string tag);
        sb_item_t it;
        sb_item_t got;
        logic [26:0] obs;
        it.exp  = word(strb, a, exp_run, exp_ill);
        it.mask = mask;
        it.tag  = tag;
        sb_q.push_back(it);
        @(negedge clock);
        clear = c;
        stop  = s;
        ir    = irv;
        #1;
        obs = {PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout, IRin,
               RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin,
               Gra, Grb, Grc, Rin, Rout, alu_op, run, illegal};
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 27'd0, 27'd1);
        end else begin
            got = sb_q.pop_front();
            check(got.tag, obs & got.mask, got.exp & got.mask);
        end
        if (c) begin
            exp_run = 1'b1;
            exp_ill = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] irv, input string tag);
        cyc(0, 0, irv, PCOUT | MARIN | INCPC | RZINLO, 5'd0, ALL, {tag, "_t0"});
        cyc(0, 0, irv, RZOUTLO | PCIN | MDRREAD | MDRIN, 5'd0, ALL, {tag, "_t1"});
        cyc(0, 0, irv, MDROUT | IRIN, 5'd0, ALL, {tag, "_t2"});
    endtask

    task automatic do_alu3(input logic [31:0] irv, input string tag);
        logic [4:0] op;
        op = irv[31:27];
        fetch(irv, tag);
        cyc(0, 0, irv, GRB | ROUT | RYIN, op, ALL, {tag, "_t3"});
        cyc(0, 0, irv, GRC | ROUT | RZINLO, op, ALL, {tag, "_t4"});
        cyc(0, 0, irv, RZOUTLO | GRA | RIN, op, ALL, {tag, "_t5"});
    endtask

    task automatic do_unary(input logic [31:0] irv, input string tag);
        logic [4:0] op;
        op = irv[31:27];
        fetch(irv, tag);
        cyc(0, 0, irv, GRB | ROUT | RZINLO, op, ALL, {tag, "_t3"});
        cyc(0, 0, irv, RZOUTLO | GRA | RIN, op, ALL, {tag, "_t4"});
    endtask

    task automatic do_muldiv(input logic [31:0] irv, input int stop_cycles, input string tag);
        logic [4:0] op;
        op = irv[31:27];
        fetch(irv, tag);
        cyc(0, 0, irv, GRA | ROUT | RYIN, op, ALL, {tag, "_t3"});
        for (int i = 0; i < stop_cycles; i++) begin
            cyc(0, 1, irv, NONE, 5'd0, NOALU, {tag, "_stop"});
        end
        cyc(0, 0, irv, GRB | ROUT | RZINLO | RZINHI, op, ALL, {tag, "_t4"});
        cyc(0, 0, irv, RZOUTLO | LOIN, op, ALL, {tag, "_t5"});
        cyc(0, 0, irv, RZOUTHI | HIIN, op, ALL, {tag, "_t6"});
    endtask

    initial begin
        @(posedge clock);
        cyc(1, 0, '0, NONE, 5'd0, ALL, "reset");

        do_muldiv(IR_DIV, 0, "div");
        do_alu3(IR_ADD, "add_a");
        do_alu3(IR_ADD, "add_b");
        do_unary(IR_NEG, "neg");
        do_unary(IR_NOT, "not");
        fetch(IR_NOP, "nop");
        do_alu3(IR_ADD, "add_after_nop");

        fetch(IR_ILL, "ill");
        exp_ill = 1'b1;
        do_alu3(IR_ADD, "add_after_ill");
        cyc(1, 0, IR_ADD, NONE, 5'd0, NOALU, "ill_clear");
        fetch(IR_NOP, "nop_after_clear");

        do_muldiv(IR_MUL, 3, "mul_stop");

        fetch(IR_ADD, "add_abort");
        cyc(0, 0, IR_ADD, GRB | ROUT | RYIN, IR_ADD[31:27], ALL, "add_abort_t3");
        cyc(0, 0, IR_ADD, GRC | ROUT | RZINLO, IR_ADD[31:27], ALL, "add_abort_t4");
        cyc(1, 0, IR_ADD, NONE, 5'd0, NOALU, "add_abort_clear");
        cyc(0, 0, IR_ADD, PCOUT | MARIN | INCPC | RZINLO, 5'd0, ALL, "add_abort_next_t0");
        cyc(0, 0, IR_ADD, RZOUTLO | PCIN | MDRREAD | MDRIN, 5'd0, ALL, "add_abort_next_t1");
        cyc(0, 0, IR_ADD, MDROUT | IRIN, 5'd0, ALL, "add_abort_next_t2");
        cyc(0, 0, IR_ADD, GRB | ROUT | RYIN, IR_ADD[31:27], ALL, "add_abort_next_t3");
        cyc(0, 0, IR_ADD, GRC | ROUT | RZINLO, IR_ADD[31:27], ALL, "add_abort_next_t4");
        cyc(0, 0, IR_ADD, RZOUTLO | GRA | RIN, IR_ADD[31:27], ALL, "add_abort_next_t5");

        fetch(IR_HALT, "halt");
        exp_run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, IR_HALT, NONE, 5'd0, ALL, "halt_idle");
        end
        cyc(1, 0, IR_HALT, NONE, 5'd0, NOALU, "halt_clear");
        fetch(IR_NOP, "after_halt");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
